// File: rtl/tlut_sweep_capture_pkg.sv
// Shared state encoding and constants for the temporal-LUT sweep capture block.
// Build option TLUT_EARLY_EXIT_EN selects the early-exit sweep variant in tlut_sweep_capture.
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 8
`endif

package tlut_pkg;

    localparam int IN_W_DEF = `INPUT_WIDTH;
    localparam logic [IN_W_DEF-1:0] CNT_MAX = {IN_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/tlut_sweep_capture_if.sv
// Operand, counter-side and result signals of the sweep capture block.
// slave = the capture block, master = whatever drives operands and hosts the counter/LUT.
interface tlut_sweep_capture_if #(
    parameter int IN_W   = `INPUT_WIDTH,
    parameter int DATA_W = 16
);
    logic              op_valid;
    logic              op_ready;
    logic [IN_W-1:0]   op_a;
    logic [IN_W-1:0]   cnt_in;
    logic              rollover_in;
    logic [DATA_W-1:0] lut_data;
    logic              cnt_en;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    modport master (
        output op_valid, op_a, cnt_in, rollover_in, lut_data, res_ready,
        input  op_ready, cnt_en, res_valid, res_data
    );

    modport slave (
        input  op_valid, op_a, cnt_in, rollover_in, lut_data, res_ready,
        output op_ready, cnt_en, res_valid, res_data
    );
endinterface

// File: rtl/tlut_sweep_capture_match_latch.sv
// Compares the broadcast count with the job operand and latches the LUT word on a hit.
// Latency: result register updates on the edge after the matching cycle; no backpressure.
module tlut_match_latch
    import tlut_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   cnt_i,
    input  logic [IN_W-1:0]   op_i,
    input  logic [DATA_W-1:0] lut_i,
    input  logic              cap_en_i,
    output logic              match_o,
    output logic [DATA_W-1:0] res_o
);

    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] res_d;

    assign match_o = (cnt_i == op_i);

    always_comb begin
        res_d = res_q;
        if (cap_en_i && match_o) begin
            res_d = lut_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/tlut_sweep_capture.sv
// Runs the sweep counter for one aligned sweep per operand and captures the LUT word at cnt==op.
// Latency 2^IN_W+1 (op+2 with TLUT_EARLY_EXIT_EN) from an aligned counter; result held until res_ready.
module tlut_sweep_capture
    import tlut_pkg::*;
#(
    parameter int IN_W   = `INPUT_WIDTH,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    tlut_sweep_capture_if.slave  bus
);

    localparam logic [IN_W-1:0] LAST_CNT = {IN_W{1'b1}};

    sweep_state_t      state_q;
    sweep_state_t      state_d;
    logic [IN_W-1:0]   op_q;
    logic [IN_W-1:0]   op_d;
    logic              op_ready_q;
    logic              cnt_en_q;
    logic              res_valid_q;
    logic              cap_en;
    logic              match;
    logic [DATA_W-1:0] res_data;

    tlut_match_latch #(
        .IN_W   (IN_W),
        .DATA_W (DATA_W)
    ) u_match_latch (
        .clk      (clk),
        .rst      (rst),
        .cnt_i    (bus.cnt_in),
        .op_i     (op_q),
        .lut_i    (bus.lut_data),
        .cap_en_i (cap_en),
        .match_o  (match),
        .res_o    (res_data)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cap_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.op_valid && op_ready_q) begin
                    op_d    = bus.op_a;
                    state_d = ARM;
                end
            end
            ARM: begin
                // cnt_in is 0 on rollover, so the latch only loads here when op_q==0
                if (bus.rollover_in) begin
                    cap_en = 1'b1;
`ifdef TLUT_EARLY_EXIT_EN
                    state_d = match ? DONE : SWEEP;
`else
                    state_d = SWEEP;
`endif
                end
            end
            SWEEP: begin
                cap_en = 1'b1;
                if (bus.cnt_in == LAST_CNT) begin
                    state_d = DONE;
                end
`ifdef TLUT_EARLY_EXIT_EN
                if (match) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            op_ready_q  <= 1'b0;
            cnt_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            op_ready_q  <= (state_d == IDLE);
            cnt_en_q    <= (state_d == ARM) || (state_d == SWEEP);
            res_valid_q <= (state_d == DONE);
        end
    end

    assign bus.op_ready  = op_ready_q;
    assign bus.cnt_en    = cnt_en_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data;

endmodule
